// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU self-test: opcodes, flag bit
// positions and the sweeper FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int FLAG_OV = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 0;

  localparam int         VEC_W    = 11;
  localparam logic [10:0] LAST_IDX = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: {op,a,b} -> expected result
// and {overflow, carry, zero}.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_exp_result,
  output logic [2:0] o_exp_flags
);

  logic [4:0] w_sum;
  logic [3:0] w_res;
  logic       w_ov;
  logic       w_c;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_ov  = 1'b0;
    w_c   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_ov  = (i_a[3] == i_b[3]) && (w_res[3] != i_a[3]);
      end
      OP_SUB: begin
        // carry is the 5-bit carry-out of a + ~b + 1 (1 means no borrow)
        w_sum = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_ov  = (i_a[3] != i_b[3]) && (w_res[3] != i_a[3]);
      end
      OP_NOT:  w_res = ~i_a;
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_LT:   w_res = {3'b000, ($signed(i_a) < $signed(i_b))};
      OP_EQ:   w_res = {3'b000, (i_a == i_b)};
      default: w_res = '0;
    endcase
  end

  assign o_exp_result         = w_res;
  assign o_exp_flags[FLAG_OV] = w_ov;
  assign o_exp_flags[FLAG_C]  = w_c;
  assign o_exp_flags[FLAG_Z]  = (w_res == 4'd0);

endmodule

// File: rtl/alu_sweeper.sv
// Walks all 2048 {op,a,b} vectors into the ALU under test, compares each
// response with the golden model and reports pass, error count, first failure.
module alu_sweeper
  import alu_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_on_err,
  output logic        en,
  output logic [2:0]  op,
  output logic [3:0]  a,
  output logic [3:0]  b,
  input  logic [3:0]  result,
  input  logic [2:0]  flags,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [11:0] err_cnt,
  output logic [10:0] fail_vec
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_t      r_state;
  logic [10:0] r_idx;
  logic [15:0] r_settle_cnt;
  logic        r_stop;
  logic        r_en;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [11:0] r_err_cnt;
  logic [10:0] r_fail_vec;

  logic [3:0]  w_exp_result;
  logic [2:0]  w_exp_flags;
  logic        w_mismatch;
  logic [11:0] w_err_next;

  alu_ref_model u_ref (
    .i_op         (r_idx[10:8]),
    .i_a          (r_idx[7:4]),
    .i_b          (r_idx[3:0]),
    .o_exp_result (w_exp_result),
    .o_exp_flags  (w_exp_flags)
  );

  assign w_mismatch = ({result, flags} != {w_exp_result, w_exp_flags});
  assign w_err_next = r_err_cnt + {11'd0, w_mismatch};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_stop       <= 1'b0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_stop       <= stop_on_err;
            r_en         <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        ST_CHECK: begin
          r_err_cnt <= w_err_next;
          if (w_mismatch && (r_err_cnt == 12'd0)) begin
            r_fail_vec <= r_idx;
          end
          // on the last vector or a stopping mismatch, op/a/b stay put
          if ((r_idx == LAST_IDX) || (w_mismatch && r_stop)) begin
            r_state <= ST_DONE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 12'd0);
          end else begin
            r_idx   <= r_idx + 11'd1;
            r_state <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en       = r_en;
  assign op       = r_idx[10:8];
  assign a        = r_idx[7:4];
  assign b        = r_idx[3:0];
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_alu_sweeper.sv
// Bench for alu_sweeper: a behavioural ALU with selectable faults closes the
// loop; directed sweeps check counts, first-failure capture, stop and reset.
module tb_alu_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop_on_err;
  logic        en;
  logic [2:0]  op;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [3:0]  result;
  logic [2:0]  flags;
  logic        busy;
  logic        done;
  logic        pass;
  logic [11:0] err_cnt;
  logic [10:0] fail_vec;

  logic [2:0]  m_op;
  logic [3:0]  m_a;
  logic [3:0]  m_b;
  logic [3:0]  m_res;
  logic [2:0]  m_flags;

  int total = 0;
  int bad   = 0;
  int fault = 0;

  always #5 clk = ~clk;

  alu_sweeper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop_on_err (stop_on_err),
    .en          (en),
    .op          (op),
    .a           (a),
    .b           (b),
    .result      (result),
    .flags       (flags),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_cnt     (err_cnt),
    .fail_vec    (fail_vec)
  );

  alu_ref_model u_model (
    .i_op         (m_op),
    .i_a          (m_a),
    .i_b          (m_b),
    .o_exp_result (m_res),
    .o_exp_flags  (m_flags)
  );

  // Behavioural ALU in signed/unsigned integer arithmetic; returns {r, ov, c, z}
  function automatic logic [6:0] board_alu(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int ux, uy, sx, sy, s;
    logic [3:0] r;
    logic ov, c;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 8) ? ux - 16 : ux;
    sy = (uy >= 8) ? uy - 16 : uy;
    r = 4'd0; ov = 1'b0; c = 1'b0;
    case (o)
      3'd0: begin s = sx + sy; r = 4'((ux + uy) & 15); c = (ux + uy) > 15; ov = (s > 7) || (s < -8); end
      3'd1: begin s = sx - sy; r = 4'((ux - uy) & 15); c = (ux >= uy);     ov = (s > 7) || (s < -8); end
      3'd2: r = 4'(15 - ux);
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = (sx < sy) ? 4'd1 : 4'd0;
      default: r = (ux == uy) ? 4'd1 : 4'd0;
    endcase
    return {r, ov, c, (r == 4'd0)};
  endfunction

  logic [6:0] alu_out;
  always_comb begin
    alu_out = board_alu(op, a, b);
    if (fault == 1 && op == 3'd0 && a == 4'd7 && b == 4'd1) alu_out[6:3] = 4'd0;
    if (fault == 2 && op == 3'd1 && a == 4'd0 && b == 4'd0) alu_out[0] = 1'b0;
  end
  assign result = alu_out[6:3];
  assign flags  = alu_out[2:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse start, optionally poke start again mid-sweep, count busy cycles until done
  task automatic run_sweep(input string name, input bit stop, input bit poke, output int busy_n);
    int cyc;
    @(negedge clk);
    start       = 1'b1;
    stop_on_err = stop;
    busy_n = 0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({name, "_start_busy_en"}, {busy, en, done}, 3'b110);
        check({name, "_start_vec"}, {op, a, b}, 11'd0);
        check({name, "_start_cleared"}, {err_cnt, fail_vec}, 23'd0);
      end
      start = (poke && cyc == 50);
      if (busy) busy_n++;
      if (done) break;
      if (cyc > 20000) begin
        check({name, "_timeout"}, 1'b0, 1'b1);
        break;
      end
    end
    start = 1'b0;
    $display("sweep %s: busy_cycles=%0d err_cnt=%0d pass=%0d fail_vec=%0h", name, busy_n, err_cnt, pass, fail_vec);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop_on_err = 1'b0;
    m_op = 3'd0; m_a = 4'd0; m_b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {en, op, a, b, busy, done, pass, err_cnt, fail_vec}, 64'd0);
    rst_n = 1'b1;

    m_op = 3'b001; m_a = 4'h0; m_b = 4'h1; #1;
    check("model_sub_0_1", {m_res, m_flags}, {4'hF, 3'b000});
    m_op = 3'b000; m_a = 4'h7; m_b = 4'h1; #1;
    check("model_add_7_1", {m_res, m_flags}, {4'h8, 3'b100});
    m_op = 3'b110; m_a = 4'h8; m_b = 4'h7; #1;
    check("model_lt_8_7", {m_res, m_flags}, {4'h1, 3'b000});
    m_op = 3'b001; m_a = 4'h0; m_b = 4'h0; #1;
    check("model_sub_0_0", {m_res, m_flags}, {4'h0, 3'b011});
    m_op = 3'b111; m_a = 4'h5; m_b = 4'h6; #1;
    check("model_eq_5_6", {m_res, m_flags}, {4'h0, 3'b001});

    fault = 0;
    run_sweep("clean", 1'b0, 1'b1, n);
    check("clean_busy_cycles", n, 4096);
    check("clean_status", {done, busy, en, pass}, 4'b1001);
    check("clean_err_fail", {err_cnt, fail_vec}, 23'd0);
    check("clean_last_vec", {op, a, b}, 11'h7FF);

    fault = 1;
    run_sweep("add_fault", 1'b0, 1'b0, n);
    check("add_fault_busy_cycles", n, 4096);
    check("add_fault_err_cnt", err_cnt, 12'd1);
    check("add_fault_fail_vec", fail_vec, {3'b000, 4'h7, 4'h1});
    check("add_fault_pass", {done, pass}, 2'b10);

    fault = 2;
    run_sweep("sub_stop", 1'b1, 1'b0, n);
    check("sub_stop_busy_cycles", n, 514);
    check("sub_stop_err_cnt", err_cnt, 12'd1);
    check("sub_stop_held_vec", {op, a, b}, {3'b001, 4'h0, 4'h0});
    check("sub_stop_fail_vec", fail_vec, {3'b001, 4'h0, 4'h0});
    check("sub_stop_status", {done, busy, en, pass}, 4'b1000);

    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({op, a, b} != 11'd100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_vec100", {op, a, b}, 11'd100);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {en, op, a, b, busy, done, pass, err_cnt, fail_vec}, 64'd0);
    rst_n = 1'b1;
    $display("reset at vector 100: busy=%0d done=%0d", busy, done);
    run_sweep("after_reset", 1'b0, 1'b0, n);
    check("after_reset_busy_cycles", n, 4096);
    check("after_reset_pass", {done, pass, err_cnt}, {2'b11, 12'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
